// File: rtl/mem_drain_pkg.sv
// Shared sizing, FSM state encoding and source-select encoding for the event-memory drain sequencer.
package mem_drain_pkg;

    localparam int NMEM   = 12;
    localparam int NENT_W = 6;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 36;
    localparam int RD_LAT = 2;
    localparam int SEL_W  = 4;
    localparam int FCNT_W = $clog2(RD_LAT + 1);

    localparam logic [SEL_W-1:0] SEL_NONE = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // dout_sel reports blocks 1-based so that 0 can mean "no source"
    function automatic logic [SEL_W-1:0] sel_enc(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/prio_pick_next.sv
// Lowest-set-bit picker: block 0 has the highest priority.
module prio_pick_next
    import mem_drain_pkg::*;
(
    input  logic [NMEM-1:0]  i_mask,
    output logic [NMEM-1:0]  o_onehot,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int k = NMEM - 1; k >= 0; k--) begin
            if (i_mask[k]) begin
                o_onehot    = '0;
                o_onehot[k] = 1'b1;
                o_idx       = SEL_W'(k);
                o_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_drain_seq.sv
// Drains the per-block event memories in priority order and merges the returned words into one stream.
//   state    | meaning
//   ST_IDLE  | waiting for start, counts sampled on start
//   ST_READ  | one read per cycle, lowest pending block first
//   ST_FLUSH | reads finished, waiting for in-flight returns
//   ST_DONE  | one-cycle done pulse
module mem_drain_seq
    import mem_drain_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [NMEM*NENT_W-1:0]   i_nent,
    output logic [NMEM-1:0]          o_rd_en,
    output logic [ADDR_W-1:0]        o_rd_addr,
    input  logic [NMEM*DATA_W-1:0]   i_rd_data,
    output logic [DATA_W-1:0]        o_dout,
    output logic                     o_dout_valid,
    output logic [SEL_W-1:0]         o_dout_sel,
    output logic                     o_busy,
    output logic                     o_done
);

    state_t                  r_state, w_state_nxt;
    logic [NMEM*NENT_W-1:0]  r_nent;
    logic [NMEM-1:0]         r_pend;
    logic [NMEM-1:0]         r_cur_oh;
    logic [SEL_W-1:0]        r_cur_idx;
    logic [NENT_W-1:0]       r_cnt;
    logic [SEL_W-1:0]        r_iss_idx;
    logic [RD_LAT-1:0]       r_pipe_v;
    logic [SEL_W-1:0]        r_pipe_idx [RD_LAT];
    logic [FCNT_W-1:0]       r_flush_cnt;

    logic [NMEM-1:0]         w_nz;
    logic [NMEM-1:0]         w_first_oh, w_nxt_oh;
    logic [SEL_W-1:0]        w_first_idx, w_nxt_idx;
    logic                    w_first_any, w_nxt_any;
    logic [NENT_W-1:0]       w_nent_cur;
    logic                    w_last;
    logic                    w_issue;
    logic                    w_inflight;
    logic [DATA_W-1:0]       w_mux;

    always_comb begin
        w_nz = '0;
        for (int k = 0; k < NMEM; k++) begin
            w_nz[k] = |i_nent[k*NENT_W +: NENT_W];
        end
    end

    prio_pick_next u_pick_first (
        .i_mask   (w_nz),
        .o_onehot (w_first_oh),
        .o_idx    (w_first_idx),
        .o_any    (w_first_any)
    );

    prio_pick_next u_pick_next (
        .i_mask   (r_pend & ~r_cur_oh),
        .o_onehot (w_nxt_oh),
        .o_idx    (w_nxt_idx),
        .o_any    (w_nxt_any)
    );

    always_comb begin
        w_nent_cur = '0;
        for (int k = 0; k < NMEM; k++) begin
            if (r_cur_oh[k]) w_nent_cur = r_nent[k*NENT_W +: NENT_W];
        end
    end

    always_comb begin
        w_mux = '0;
        for (int k = 0; k < NMEM; k++) begin
            if (r_pipe_idx[RD_LAT-1] == SEL_W'(k)) w_mux = i_rd_data[k*DATA_W +: DATA_W];
        end
    end

    assign w_last     = (r_cnt == w_nent_cur - NENT_W'(1));
    assign w_inflight = (|o_rd_en) || (|r_pipe_v);
    assign o_busy     = (r_state == ST_READ) || (r_state == ST_FLUSH);
    assign o_done     = (r_state == ST_DONE);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = w_first_any ? ST_READ : ST_FLUSH;
            ST_READ: begin
                w_issue = 1'b1;
                if (w_last && !w_nxt_any) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: if (r_flush_cnt == '0 && !w_inflight) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_nent       <= '0;
            r_pend       <= '0;
            r_cur_oh     <= '0;
            r_cur_idx    <= '0;
            r_cnt        <= '0;
            r_iss_idx    <= '0;
            r_pipe_v     <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe_idx[i] <= '0;
            r_flush_cnt  <= '0;
            o_rd_en      <= '0;
            o_rd_addr    <= '0;
            o_dout       <= '0;
            o_dout_valid <= 1'b0;
            o_dout_sel   <= SEL_NONE;
        end else begin
            o_rd_en   <= w_issue ? r_cur_oh : '0;
            o_rd_addr <= w_issue ? ADDR_W'(r_cnt) : '0;
            r_iss_idx <= r_cur_idx;

            // o_rd_en is the first latency stage; the shift register covers the rest
            r_pipe_v[0]   <= |o_rd_en;
            r_pipe_idx[0] <= r_iss_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_v[i]   <= r_pipe_v[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end

            if (r_state == ST_IDLE && i_start) begin
                r_nent    <= i_nent;
                r_pend    <= w_nz;
                r_cur_oh  <= w_first_oh;
                r_cur_idx <= w_first_idx;
                r_cnt     <= '0;
            end else if (w_issue) begin
                if (w_last) begin
                    r_pend    <= r_pend & ~r_cur_oh;
                    r_cur_oh  <= w_nxt_oh;
                    r_cur_idx <= w_nxt_idx;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + NENT_W'(1);
                end
            end

            // Minimum flush dwell gives an empty event the same done latency as the read pipe
            if (w_state_nxt == ST_FLUSH && r_state != ST_FLUSH)
                r_flush_cnt <= FCNT_W'(RD_LAT);
            else if (r_state == ST_FLUSH && r_flush_cnt != '0)
                r_flush_cnt <= r_flush_cnt - FCNT_W'(1);

            o_dout_valid <= r_pipe_v[RD_LAT-1];
            o_dout_sel   <= r_pipe_v[RD_LAT-1] ? sel_enc(r_pipe_idx[RD_LAT-1]) : SEL_NONE;
            if (r_pipe_v[RD_LAT-1]) o_dout <= w_mux;
        end
    end

endmodule

// File: tb/tb_mem_drain_seq.sv
// Self-checking bench for mem_drain_seq: table-driven events, corner sequences and random events vs a queue model.
module tb_mem_drain_seq;
    import mem_drain_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [NMEM*NENT_W-1:0]  nent_in;
    logic [NMEM-1:0]         rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic [NMEM*DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]       dout;
    logic                    dout_valid;
    logic [SEL_W-1:0]        dout_sel;
    logic                    busy;
    logic                    done;

    int n_checks = 0;
    int n_err    = 0;
    logic [25:0] salt = '0;

    always #5 clk = ~clk;

    mem_drain_seq dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_nent       (nent_in),
        .o_rd_en      (rd_en),
        .o_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .o_dout_sel   (dout_sel),
        .o_busy       (busy),
        .o_done       (done)
    );

    function automatic logic [DATA_W-1:0] mem_word(input int k, input int a);
        return {4'(k), salt, 6'(a)};
    endfunction

    // Memory model: a read enabled in one cycle returns its word RD_LAT cycles later
    logic [NMEM-1:0]   m_en [RD_LAT];
    logic [ADDR_W-1:0] m_a  [RD_LAT];

    always @(posedge clk) begin
        m_en[0] <= rd_en;
        m_a[0]  <= rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            m_en[i] <= m_en[i-1];
            m_a[i]  <= m_a[i-1];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NMEM; k++) begin
            rd_data[k*DATA_W +: DATA_W] = m_en[RD_LAT-1][k] ? mem_word(k, int'(m_a[RD_LAT-1]))
                                                             : 36'h5A5A5A5A5;
        end
    end

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic scramble_nent();
        logic [95:0] r96;
        r96 = {$urandom, $urandom, $urandom};
        nent_in = r96[NMEM*NENT_W-1:0];
    endtask

    // One event: start at E0, observe every cycle t (t = edges since E0) until a few cycles past done
    task automatic run_event(input logic [NMEM*NENT_W-1:0] nent, input int pulse_t,
                             input int exp_words, input int exp_done_t);
        int qk[$];
        int qa[$];
        int rd_i, out_i, dn_cnt;
        rd_i = 0; out_i = 0; dn_cnt = 0;
        for (int k = 0; k < NMEM; k++) begin
            int n;
            n = int'(nent[k*NENT_W +: NENT_W]);
            for (int a = 0; a < n; a++) begin
                qk.push_back(k);
                qa.push_back(a);
            end
        end
        salt = 26'($urandom);
        @(negedge clk);
        nent_in = nent;
        start   = 1'b1;
        @(posedge clk);
        for (int t = 0; t <= exp_done_t + 3; t++) begin
            @(negedge clk);
            start = (t == pulse_t);
            scramble_nent();
            if (rd_en != '0) begin
                if (rd_i < qk.size()) begin
                    chk("rd_en", longint'(rd_en), longint'(1) << qk[rd_i]);
                    chk("rd_addr", longint'(rd_addr), longint'(qa[rd_i]));
                    chk("rd_slot", longint'(t), longint'(1 + rd_i));
                end else begin
                    chk("rd_extra", longint'(rd_i), longint'(qk.size()));
                end
                rd_i++;
            end
            if (dout_valid) begin
                if (out_i < qk.size()) begin
                    chk("dout_sel", longint'(dout_sel), longint'(qk[out_i] + 1));
                    chk("dout", longint'(dout), longint'(mem_word(qk[out_i], qa[out_i])));
                    chk("dout_slot", longint'(t), longint'(RD_LAT + 2 + out_i));
                end else begin
                    chk("dout_extra", longint'(out_i), longint'(qk.size()));
                end
                out_i++;
            end else begin
                chk("sel_idle", longint'(dout_sel), 0);
            end
            if (done) begin
                dn_cnt++;
                chk("done_time", longint'(t), longint'(exp_done_t));
            end
            chk("busy", longint'(busy), longint'(t < exp_done_t));
        end
        start = 1'b0;
        chk("rd_count", longint'(rd_i), longint'(exp_words));
        chk("word_count", longint'(out_i), longint'(exp_words));
        chk("done_count", longint'(dn_cnt), 1);
    endtask

    typedef struct {
        logic [NMEM*NENT_W-1:0] nent;
        int                     pulse_t;
        int                     words;
        int                     done_t;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [NMEM*NENT_W-1:0] nv;
        int cnt;

        tbl[0].nent = '0; tbl[0].nent[3*NENT_W +: NENT_W] = 6'd3;
        tbl[0].pulse_t = -1; tbl[0].words = 3;   tbl[0].done_t = 7;
        tbl[1].nent = '0; tbl[1].nent[2*NENT_W +: NENT_W] = 6'd1; tbl[1].nent[7*NENT_W +: NENT_W] = 6'd2;
        tbl[1].pulse_t = -1; tbl[1].words = 3;   tbl[1].done_t = 7;
        tbl[2].nent = '0;
        tbl[2].pulse_t = -1; tbl[2].words = 0;   tbl[2].done_t = 3;
        tbl[3].nent = '1;
        tbl[3].pulse_t = -1; tbl[3].words = 756; tbl[3].done_t = 760;
        tbl[4].nent = '0; tbl[4].nent[3*NENT_W +: NENT_W] = 6'd3;
        tbl[4].pulse_t = 2;  tbl[4].words = 3;   tbl[4].done_t = 7;
        tbl[5].nent = '0; tbl[5].nent[0 +: NENT_W] = 6'd1;
        tbl[5].pulse_t = 5;  tbl[5].words = 1;   tbl[5].done_t = 5;
        tbl[6].nent = '0; tbl[6].nent[11*NENT_W +: NENT_W] = 6'd63; tbl[6].nent[0 +: NENT_W] = 6'd2;
        tbl[6].pulse_t = 10; tbl[6].words = 65;  tbl[6].done_t = 69;
        tbl[7].nent = '0;
        tbl[7].pulse_t = 1;  tbl[7].words = 0;   tbl[7].done_t = 3;

        reset   = 1'b1;
        start   = 1'b0;
        nent_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", longint'(rd_en), 0);
        chk("rst_dout_valid", longint'(dout_valid), 0);
        chk("rst_dout_sel", longint'(dout_sel), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_event(tbl[i].nent, tbl[i].pulse_t, tbl[i].words, tbl[i].done_t);
        end

        // Reset in the middle of block 5: outputs clear next cycle, in-flight words and done are dropped
        nv = '0;
        nv[2*NENT_W +: NENT_W] = 6'd4;
        nv[5*NENT_W +: NENT_W] = 6'd20;
        salt = 26'($urandom);
        @(negedge clk);
        nent_in = nv;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int t = 0; t < 200 && cnt < 10; t++) begin
            @(negedge clk);
            if (dout_valid && dout_sel == 4'd6) cnt++;
        end
        chk("reach_word10", longint'(cnt), 10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rd_en", longint'(rd_en), 0);
        chk("mid_rd_addr", longint'(rd_addr), 0);
        chk("mid_dout", longint'(dout), 0);
        chk("mid_dout_valid", longint'(dout_valid), 0);
        chk("mid_dout_sel", longint'(dout_sel), 0);
        chk("mid_busy", longint'(busy), 0);
        chk("mid_done", longint'(done), 0);
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("post_rst_valid", longint'(dout_valid), 0);
            chk("post_rst_done", longint'(done), 0);
            chk("post_rst_rd_en", longint'(rd_en), 0);
        end
        run_event(tbl[1].nent, -1, tbl[1].words, tbl[1].done_t);

        // Random events: expected word count and done time follow from the counts alone
        for (int e = 0; e < 10; e++) begin
            int w, dt;
            w = 0;
            nv = '0;
            for (int k = 0; k < NMEM; k++) begin
                int r, n;
                r = int'($urandom_range(0, 7));
                n = (r < 3) ? 0 : (r == 7) ? 63 : int'($urandom_range(1, 9));
                nv[k*NENT_W +: NENT_W] = 6'(n);
                w += n;
            end
            dt = (w == 0) ? 3 : w + RD_LAT + 2;
            run_event(nv, int'($urandom_range(0, dt)), w, dt);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
